// File: rtl/pipe_stage_buf_if.sv
// Valid/ready payload bus between pipeline stages.
//   valid  producer -> consumer  entry on the bus is valid
//   ready  consumer -> producer  consumer takes the entry this cycle
//   data   producer -> consumer  data payload (operands, PC, immediates)
//   ctrl   producer -> consumer  control payload (RegWrite, MemWrite, ...)
// master = producer side, slave = consumer side.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 12
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline stage register with valid/ready handshake, flush
// and an optional skid entry. An empty slot always presents ctrl = 0.
// Ports:
//   clk        clock, all state changes on posedge
//   reset      synchronous active-high reset (highest priority)
//   flush      drop every held entry; an accept in the same cycle is lost
//   in_if      upstream bus (slave): valid/data/ctrl in, ready out
//   out_if     downstream bus (master): head valid/data/ctrl out, ready in
//   occupancy  number of held entries (0..2; max 1 when SKID=0)
// Parameters:
//   DATA_W, CTRL_W  payload widths
//   SKID            1 = two entries, registered in_ready; 0 = one entry
//   CLR_DATA        1 = data registers also cleared on reset/flush
module pipe_stage_buf #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CTRL_W   = 12,
  parameter int unsigned SKID     = 1,
  parameter int unsigned CLR_DATA = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  pipe_stage_buf_if.slave         in_if,
  pipe_stage_buf_if.master        out_if,
  output logic [1:0]              occupancy
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] head_data_q;
  logic [CTRL_W-1:0] head_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  logic accept;
  logic consume;

  // With SKID=0 the TWO state is unreachable: in_ready is low whenever the
  // head is full and not being consumed, so the shared FSM never fills skid.
  always_comb begin
    if (SKID != 0) begin
      in_if.ready = (state_q != TWO);
    end else begin
      in_if.ready = (state_q == EMPTY) || out_if.ready;
    end
  end

  assign out_if.valid = (state_q != EMPTY);
  assign out_if.data  = head_data_q;
  // head_ctrl_q is cleared whenever the stage empties, so no gating needed.
  assign out_if.ctrl  = head_ctrl_q;

  always_comb begin
    case (state_q)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign accept  = in_if.valid & in_if.ready;
  assign consume = out_if.valid & out_if.ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q     <= EMPTY;
      head_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      if (CLR_DATA != 0) begin
        head_data_q <= '0;
        skid_data_q <= '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_data_q <= in_if.data;
            head_ctrl_q <= in_if.ctrl;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            head_data_q <= in_if.data;
            head_ctrl_q <= in_if.ctrl;
          end else if (accept) begin
            skid_data_q <= in_if.data;
            skid_ctrl_q <= in_if.ctrl;
            state_q     <= TWO;
          end else if (consume) begin
            head_ctrl_q <= '0;
            state_q     <= EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            head_data_q <= skid_data_q;
            head_ctrl_q <= skid_ctrl_q;
            skid_ctrl_q <= '0;
            state_q     <= ONE;
          end
        end
        default: begin
          head_ctrl_q <= '0;
          skid_ctrl_q <= '0;
          state_q     <= EMPTY;
        end
      endcase
    end
  end

endmodule
